// File: rtl/xor_frame_acc.sv
//------------------------------------------------------------------------------
// Module      : xor_frame_acc
// Description : Folds a frame of WIDTH-bit words into a bitwise-XOR checksum
//               plus a reduction parity bit, presented on a valid/ready port.
//               Optional expected-value check enabled by defining XOR_CHECK_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module xor_frame_acc #(
    parameter  int WIDTH   = 8,
    parameter  int MAX_LEN = 16,
    localparam int LW      = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_xor,
    output logic             out_parity,
    output logic [LW-1:0]    out_len,
    output logic             out_ovf
`ifdef XOR_CHECK_EN
    ,
    input  logic [WIDTH-1:0] exp_data,
    output logic             out_err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [LW-1:0] c_max_len = LW'(MAX_LEN);

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic [LW-1:0]    r_len;
    logic [WIDTH-1:0] r_out_xor;
    logic             r_out_parity;
    logic [LW-1:0]    r_out_len;
    logic             r_out_ovf;
`ifdef XOR_CHECK_EN
    logic             r_out_err;
`endif

    logic             w_accept;
    logic [WIDTH-1:0] w_acc_next;
    logic [LW-1:0]    w_len_next;
    logic             w_close;

    assign in_ready   = (r_state != S_DONE) & ~rst;
    assign out_valid  = (r_state == S_DONE);
    assign w_accept   = in_valid & in_ready;

    // The first beat of a frame loads rather than folds into the accumulator.
    assign w_acc_next = (r_state == S_IDLE) ? in_data : (r_acc ^ in_data);
    assign w_len_next = r_len + LW'(1);
    assign w_close    = in_last | (w_len_next == c_max_len);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_acc        <= '0;
            r_len        <= '0;
            r_out_xor    <= '0;
            r_out_parity <= 1'b0;
            r_out_len    <= '0;
            r_out_ovf    <= 1'b0;
`ifdef XOR_CHECK_EN
            r_out_err    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_ACCUM: begin
                    if (w_accept) begin
                        r_acc <= w_acc_next;
                        r_len <= w_len_next;
                        if (w_close) begin
                            r_state      <= S_DONE;
                            r_out_xor    <= w_acc_next;
                            r_out_parity <= ^w_acc_next;
                            r_out_len    <= w_len_next;
                            r_out_ovf    <= ~in_last;
`ifdef XOR_CHECK_EN
                            r_out_err    <= (w_acc_next != exp_data);
`endif
                        end else begin
                            r_state <= S_ACCUM;
                        end
                    end
                end
                S_DONE: begin
                    // Result registers are zeroed on hand-off so they read 0 outside DONE.
                    if (out_ready) begin
                        r_state      <= S_IDLE;
                        r_acc        <= '0;
                        r_len        <= '0;
                        r_out_xor    <= '0;
                        r_out_parity <= 1'b0;
                        r_out_len    <= '0;
                        r_out_ovf    <= 1'b0;
`ifdef XOR_CHECK_EN
                        r_out_err    <= 1'b0;
`endif
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign out_xor    = r_out_xor;
    assign out_parity = r_out_parity;
    assign out_len    = r_out_len;
    assign out_ovf    = r_out_ovf;
`ifdef XOR_CHECK_EN
    assign out_err    = r_out_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_xor_frame_acc.sv
//------------------------------------------------------------------------------
// Module      : tb_xor_frame_acc
// Description : Self-checking bench for xor_frame_acc (WIDTH=8, MAX_LEN=4).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_xor_frame_acc;

    localparam int WIDTH   = 8;
    localparam int MAX_LEN = 4;
    localparam int LW      = 3;
    localparam int NV      = 27;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_xor;
    logic             out_parity;
    logic [LW-1:0]    out_len;
    logic             out_ovf;
    logic [WIDTH-1:0] exp_data;
    logic             a_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

`ifdef XOR_CHECK_EN
    logic out_err;
    assign a_err = out_err;
`else
    assign a_err = 1'b0;
`endif

    xor_frame_acc #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_xor    (out_xor),
        .out_parity (out_parity),
        .out_len    (out_len),
        .out_ovf    (out_ovf)
`ifdef XOR_CHECK_EN
        ,
        .exp_data   (exp_data),
        .out_err    (out_err)
`endif
    );

    typedef struct {
        logic             v;
        logic [WIDTH-1:0] d;
        logic             l;
        logic             r;
        logic [WIDTH-1:0] ex;
        logic             e_ov;
        logic             e_ir;
        logic [WIDTH-1:0] e_x;
        logic             e_p;
        logic [LW-1:0]    e_len;
        logic             e_ovf;
    } vec_t;

    vec_t tbl [NV];

    function automatic vec_t mk(logic v, logic [7:0] d, logic l, logic r, logic [7:0] ex,
                                logic ov, logic ir, logic [7:0] x, logic p,
                                logic [2:0] len, logic ovf);
        vec_t t;
        t.v = v; t.d = d; t.l = l; t.r = r; t.ex = ex;
        t.e_ov = ov; t.e_ir = ir; t.e_x = x; t.e_p = p; t.e_len = len; t.e_ovf = ovf;
        return t;
    endfunction

    task automatic check(input string name, input logic e_ov, input logic e_ir,
                         input logic [7:0] e_x, input logic e_p, input logic [2:0] e_len,
                         input logic e_ovf, input logic e_err);
        logic ok;
        ok = (out_valid === e_ov) && (in_ready === e_ir) && (out_xor === e_x) &&
             (out_parity === e_p) && (out_len === e_len) && (out_ovf === e_ovf);
`ifdef XOR_CHECK_EN
        ok = ok && (a_err === e_err);
`endif
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s @%0t: got ov=%0b ir=%0b xor=%h par=%0b len=%0d ovf=%0b err=%0b; want ov=%0b ir=%0b xor=%h par=%0b len=%0d ovf=%0b err=%0b",
                     name, $time, out_valid, in_ready, out_xor, out_parity, out_len, out_ovf, a_err,
                     e_ov, e_ir, e_x, e_p, e_len, e_ovf, e_err);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic l,
                         input logic r, input logic [7:0] ex);
        in_valid = v; in_data = d; in_last = l; out_ready = r; exp_data = ex;
    endtask

    // Reference model: frame held as a list of words, result derived by folding it.
    logic [7:0] mq [$];
    logic       m_have;
    logic [7:0] m_xor;
    logic [2:0] m_len;
    logic       m_ovf;
    logic       m_err;

    task automatic model_step();
        logic [7:0] x;
        if (m_have) begin
            if (out_ready) m_have = 1'b0;
        end else if (in_valid) begin
            mq.push_back(in_data);
            if (in_last || mq.size() == MAX_LEN) begin
                x = 8'h00;
                foreach (mq[i]) x = x ^ mq[i];
                m_xor  = x;
                m_len  = 3'(mq.size());
                m_ovf  = !in_last;
                m_err  = (x != exp_data);
                m_have = 1'b1;
                mq.delete();
            end
        end
    endtask

    function automatic logic [7:0] fold_pending(input logic [7:0] d);
        logic [7:0] x;
        x = d;
        foreach (mq[i]) x = x ^ mq[i];
        return x;
    endfunction

    initial begin
        tbl[0]  = mk(1, 8'hA5, 1, 0, 8'hA5, 1, 0, 8'hA5, 0, 1, 0);
        tbl[1]  = mk(0, 8'h00, 0, 1, 8'h00, 0, 1, 8'h00, 0, 0, 0);
        tbl[2]  = mk(1, 8'h0F, 0, 0, 8'h00, 0, 1, 8'h00, 0, 0, 0);
        tbl[3]  = mk(0, 8'h00, 0, 0, 8'h00, 0, 1, 8'h00, 0, 0, 0);
        tbl[4]  = mk(0, 8'h00, 0, 0, 8'h00, 0, 1, 8'h00, 0, 0, 0);
        tbl[5]  = mk(1, 8'hF0, 0, 0, 8'h00, 0, 1, 8'h00, 0, 0, 0);
        tbl[6]  = mk(1, 8'h33, 1, 0, 8'hCC, 1, 0, 8'hCC, 0, 3, 0);
        for (int i = 7; i < 12; i++)
            tbl[i] = mk(1, 8'h55, 1, 0, 8'h55, 1, 0, 8'hCC, 0, 3, 0);
        tbl[12] = mk(1, 8'h55, 1, 1, 8'h55, 0, 1, 8'h00, 0, 0, 0);
        tbl[13] = mk(1, 8'h55, 1, 0, 8'h55, 1, 0, 8'h55, 0, 1, 0);
        tbl[14] = mk(0, 8'h00, 0, 1, 8'h00, 0, 1, 8'h00, 0, 0, 0);
        tbl[15] = mk(1, 8'h01, 0, 0, 8'h00, 0, 1, 8'h00, 0, 0, 0);
        tbl[16] = mk(1, 8'h02, 0, 0, 8'h00, 0, 1, 8'h00, 0, 0, 0);
        tbl[17] = mk(1, 8'h04, 0, 0, 8'h00, 0, 1, 8'h00, 0, 0, 0);
        tbl[18] = mk(1, 8'h08, 0, 0, 8'h0F, 1, 0, 8'h0F, 0, 4, 1);
        tbl[19] = mk(1, 8'h10, 1, 1, 8'h10, 0, 1, 8'h00, 0, 0, 0);
        tbl[20] = mk(1, 8'h10, 1, 0, 8'h10, 1, 0, 8'h10, 1, 1, 0);
        tbl[21] = mk(0, 8'h00, 0, 1, 8'h00, 0, 1, 8'h00, 0, 0, 0);
        tbl[22] = mk(1, 8'h11, 0, 0, 8'h00, 0, 1, 8'h00, 0, 0, 0);
        tbl[23] = mk(1, 8'h22, 0, 0, 8'h00, 0, 1, 8'h00, 0, 0, 0);
        tbl[24] = mk(1, 8'h44, 0, 0, 8'h00, 0, 1, 8'h00, 0, 0, 0);
        tbl[25] = mk(1, 8'h88, 1, 0, 8'hFF, 1, 0, 8'hFF, 0, 4, 0);
        tbl[26] = mk(0, 8'h00, 0, 1, 8'h00, 0, 1, 8'h00, 0, 0, 0);

        rst = 1'b1;
        drive(0, 8'h00, 0, 0, 8'h00);
        tick();
        tick();
        check("reset_state", 0, 0, 8'h00, 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        check("reset_release", 0, 1, 8'h00, 0, 0, 0, 0);

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].r, tbl[i].ex);
            tick();
            check($sformatf("vec%0d", i), tbl[i].e_ov, tbl[i].e_ir, tbl[i].e_x,
                  tbl[i].e_p, tbl[i].e_len, tbl[i].e_ovf, 1'b0);
        end

        // Reset two beats into a frame must discard the partial accumulation.
        drive(1, 8'hAA, 0, 0, 8'h00);
        tick();
        drive(1, 8'hBB, 0, 0, 8'h00);
        tick();
        drive(0, 8'h00, 0, 0, 8'h00);
        rst = 1'b1;
        #1;
        check("rst_midframe", 0, 0, 8'h00, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        #1;
        check("rst_mid_release", 0, 1, 8'h00, 0, 0, 0, 0);
        drive(1, 8'h3C, 1, 0, 8'h3C);
        tick();
        check("after_rst_frame", 1, 0, 8'h3C, 0, 1, 0, 0);
        drive(0, 8'h00, 0, 1, 8'h00);
        tick();
        check("after_rst_take", 0, 1, 8'h00, 0, 0, 0, 0);

        // Reset while a result is pending drops it with no later output.
        drive(1, 8'h81, 1, 0, 8'h81);
        tick();
        check("done_before_rst", 1, 0, 8'h81, 0, 1, 0, 0);
        drive(0, 8'h00, 0, 0, 8'h00);
        rst = 1'b1;
        #1;
        check("rst_in_done", 0, 0, 8'h00, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        #1;
        check("rst_done_release", 0, 1, 8'h00, 0, 0, 0, 0);
        tick();
        check("rst_done_no_pulse", 0, 1, 8'h00, 0, 0, 0, 0);

`ifdef XOR_CHECK_EN
        // exp_data only matters on the closing beat.
        drive(1, 8'h0F, 0, 0, 8'hCD); tick();
        drive(1, 8'hF0, 0, 0, 8'hCD); tick();
        drive(1, 8'h33, 1, 0, 8'hCC); tick();
        check("chk_match", 1, 0, 8'hCC, 0, 3, 0, 0);
        drive(0, 8'h00, 0, 1, 8'h00); tick();
        drive(1, 8'h0F, 0, 0, 8'hCC); tick();
        drive(1, 8'hF0, 0, 0, 8'hCC); tick();
        drive(1, 8'h33, 1, 0, 8'hCD); tick();
        check("chk_mismatch", 1, 0, 8'hCC, 0, 3, 0, 1);
        drive(0, 8'h00, 0, 1, 8'h00); tick();
        check("chk_clear", 0, 1, 8'h00, 0, 0, 0, 0);
`endif

        // Randomised traffic against the frame-list model.
        drive(0, 8'h00, 0, 0, 8'h00);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mq.delete();
        m_have = 1'b0; m_xor = '0; m_len = '0; m_ovf = 1'b0; m_err = 1'b0;
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            in_last   = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            exp_data  = ($urandom_range(0, 1) != 0) ? fold_pending(in_data) : 8'($urandom);
            model_step();
            tick();
            if (m_have)
                check("random", 1, 0, m_xor, 1'($countones(m_xor) % 2), m_len, m_ovf, m_err);
            else
                check("random", 0, 1, 8'h00, 0, 0, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/xor_frame_acc.md
# xor_frame_acc

Streaming, parametrised successor to the single-bit XOR primitive. It folds a frame of WIDTH-bit words into one bitwise-XOR checksum word plus a reduction parity bit, and presents the result on a valid/ready output port. It sits on datapath streams wherever a frame-level XOR checksum or parity must be generated, or checked against an expected value.

## Interface
- `WIDTH`, default 8: data word width in bits (≥1).
- `MAX_LEN`, default 16: maximum beats per frame (≥1). Counter width `LW = $clog2(MAX_LEN+1)`.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  block can accept a beat.
- `in_data`  in  WIDTH  input word.
- `in_last`  in  1  final beat of the frame.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `out_xor`  out  WIDTH  XOR of all accepted words in the frame.
- `out_parity`  out  1  reduction XOR of `out_xor` (1 = odd number of ones).
- `out_len`  out  LW  number of beats in the frame.
- `out_ovf`  out  1  frame force-closed at MAX_LEN without `in_last`.
- `exp_data`  in  WIDTH  expected checksum. Present only with `XOR_CHECK_EN`.
- `out_err`  out  1  `out_xor != exp_data`. Present only with `XOR_CHECK_EN`.

## Operation
- Beat accepted ⇔ `in_valid & in_ready`. Result taken ⇔ `out_valid & out_ready`.
- `in_ready = (state != DONE) & !rst`. `out_valid = (state == DONE)`.
- States:
  - **IDLE**: accumulator = 0, len = 0.
    - On accept: acc ← `in_data`, len ← 1.
    - Go to DONE if `in_last` or MAX_LEN==1; otherwise go to ACCUM.
  - **ACCUM**:
    - On accept: acc ← acc ^ `in_data`, len ← len+1.
    - Go to DONE if `in_last` or new len == MAX_LEN.
    - `in_valid` gaps hold all state.
  - **DONE**: outputs frozen. On result taken, go to IDLE and clear acc and len.
- Overflow: the frame closes on the beat that brings len to MAX_LEN with `in_last`=0; `out_ovf` is 1. Any further beats start a new frame. If `in_last`=1 on that beat, `out_ovf` is 0.
- `out_xor`, `out_len`, `out_ovf`, `out_parity` and `out_err` are registered. They are valid only while `out_valid`=1 and read 0 in IDLE and ACCUM.
- `out_parity` is computed from the final accumulator value and registered on entry to DONE.

## Timing
- Reset (async assert, sync deassert at the bench): state IDLE; all outputs 0; `in_ready` 0 while `rst`=1 and 1 on the first cycle after release.
- Latency: `out_valid` rises on the clock edge that accepts the closing beat, i.e. it is visible the cycle after that beat.
- No bypass: `in_ready`=0 throughout DONE, so there is a minimum one-cycle bubble between frames.
- Throughput: one beat per cycle inside a frame.
- Reset mid-frame or in DONE discards the partial or pending result. No output pulse is generated.
- `out_ready` high outside DONE has no effect.

## Configuration
- `XOR_CHECK_EN` defined:
  - `exp_data` is sampled on the closing beat.
  - `out_err` is registered on entry to DONE and held with the result.
- Not defined: `exp_data` and `out_err` ports and their logic are absent. All other behaviour is identical.

## Test plan
All scenarios use WIDTH=8, MAX_LEN=4.
- Single beat 0xA5 with `in_last` → next cycle `out_valid`=1, `out_xor`=0xA5, `out_parity`=0, `out_len`=1, `out_ovf`=0.
- Beats 0x0F, 0xF0, 0x33 (last), with a 2-cycle `in_valid` gap after the first → `out_xor`=0xCC, `out_parity`=0, `out_len`=3.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE → outputs stable, `in_ready`=0, no beat accepted. Raise `out_ready` → IDLE next cycle, then the next frame is accepted.
- Overflow: 0x01, 0x02, 0x04, 0x08 with no `in_last` → `out_xor`=0x0F, `out_parity`=0, `out_len`=4, `out_ovf`=1. Following beat 0x10 (last) → new frame with `out_xor`=0x10, `out_len`=1, `out_ovf`=0.
- Assert `rst` after 2 beats of a frame → all outputs 0 immediately. A subsequent single beat 0x3C (last) → `out_xor`=0x3C, `out_len`=1.
- `XOR_CHECK_EN`: rerun the 3-beat frame with `exp_data`=0xCC → `out_err`=0; with `exp_data`=0xCD → `out_err`=1.
